// File: rtl/booth_arbiter.sv
// Round-robin front end that time-shares one sequential Booth multiplier
// between NREQ requesters and returns each product to the requester that issued it.
module booth_arbiter #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*WIDTH-1:0]     req_a,
   input  logic [NREQ*WIDTH-1:0]     req_b,
   output logic [NREQ-1:0]           rsp_valid,
   input  logic [NREQ-1:0]           rsp_ready,
   output logic [2*WIDTH-1:0]        rsp_prod,
   output logic                      busy,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic [WIDTH-1:0]          mul_a,
   output logic [WIDTH-1:0]          mul_b,
   output logic                      mul_rst,
   input  logic [2*WIDTH-1:0]        mul_out
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      CAPTURE,
      RESP
   } state_t;

   state_t               state;
   logic [IW-1:0]        ptr;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic [2*WIDTH-1:0]   prod_reg;

   logic                 found;
   logic [IW-1:0]        win;
   logic [WIDTH-1:0]     sel_a;
   logic [WIDTH-1:0]     sel_b;
   int                   idx;

   // Search starts just past the last served requester so everyone gets a turn.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
      sel_a = req_a[int'(win)*WIDTH +: WIDTH];
      sel_b = req_b[int'(win)*WIDTH +: WIDTH];
   end

   // Accept strobe is combinational so a fresh request is taken in the same IDLE cycle.
   assign req_ready = (rst && state == IDLE && found) ? (NREQ'(1) << win) : '0;

   assign mul_a    = op_a;
   assign mul_b    = op_b;
   assign rsp_prod = prod_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= IW'(NREQ - 1);
         grant_id  <= '0;
         cnt       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         prod_reg  <= '0;
         busy      <= 1'b0;
         mul_rst   <= 1'b0;
         rsp_valid <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  op_a     <= sel_a;
                  op_b     <= sel_b;
                  grant_id <= win;
                  busy     <= 1'b1;
                  mul_rst  <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               mul_rst <= 1'b0;
               cnt     <= '0;
               state   <= RUN;
            end
            // The multiplier writes its result on the same edge that leaves RUN.
            RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH)) begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               prod_reg  <= mul_out;
               rsp_valid <= NREQ'(1) << grant_id;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready[grant_id]) begin
                  rsp_valid <= '0;
                  busy      <= 1'b0;
                  ptr       <= grant_id;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_arbiter.sv
// Directed bench for booth_arbiter with a behavioural stand-in for the
// sequential multiplier that publishes its product WIDTH cycles after load.
module tb_booth_arbiter;

   localparam int W = 16;
   localparam int N = 4;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*W-1:0]    req_a;
   logic [N*W-1:0]    req_b;
   logic [N-1:0]      rsp_valid;
   logic [N-1:0]      rsp_ready;
   logic [2*W-1:0]    rsp_prod;
   logic              busy;
   logic [1:0]        grant_id;
   logic [W-1:0]      mul_a;
   logic [W-1:0]      mul_b;
   logic              mul_rst;
   logic [2*W-1:0]    mul_out;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int mk = 0;
   int rst_pulses = 0;

   int          acc_id[$];
   int          acc_cyc[$];
   int          rsp_id[$];
   logic [31:0] rsp_val[$];

   booth_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a(req_a),
      .req_b(req_b),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_prod(rsp_prod),
      .busy(busy),
      .grant_id(grant_id),
      .mul_a(mul_a),
      .mul_b(mul_b),
      .mul_rst(mul_rst),
      .mul_out(mul_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier model: load clears it, the product lands on the WIDTH-th edge after load.
   initial mul_out = '0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mul_rst) begin
         mk      <= 0;
         mul_out <= '0;
      end else begin
         mk <= mk + 1;
         if (mk == W) begin
            mul_out <= {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
         end
      end
   end

   // Records accepts and response handshakes that will occur at the coming rising edge.
   always @(negedge clk) begin
      if (mul_rst) rst_pulses++;
      if (rst && |(req_ready & req_valid)) begin
         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
               acc_id.push_back(i);
               acc_cyc.push_back(cyc + 1);
            end
         end
      end
      if (rst && |(rsp_valid & rsp_ready)) begin
         for (int i = 0; i < N; i++) begin
            if (rsp_valid[i]) begin
               rsp_id.push_back(i);
               rsp_val.push_back(rsp_prod);
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int who, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[who*W +: W] = a;
      req_b[who*W +: W] = b;
   endtask

   // Called right after the accept edge; waits for the response, holds it, then accepts it.
   task automatic wait_response(input int who, input logic [31:0] exp, input int hold);
      int n;
      logic [N-1:0] mask;
      n = 0;
      mask = N'(1) << who;
      while (rsp_valid == 0 && n < 60) begin
         tick();
         n++;
      end
      checkOutput("rsp_latency", n, W + 3);
      checkOutput("rsp_valid", rsp_valid, mask);
      checkOutput("rsp_prod", rsp_prod, exp);
      checkOutput("no_accept_in_resp", req_ready, 0);
      for (int i = 0; i < hold; i++) begin
         rsp_ready = ~mask;
         tick();
         checkOutput("rsp_held", {rsp_valid, rsp_prod}, {mask, exp});
      end
      rsp_ready = mask;
      tick();
      checkOutput("rsp_clear", rsp_valid, 0);
      checkOutput("busy_clear", busy, 0);
      rsp_ready = '0;
   endtask

   task automatic run_single(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [31:0] exp, input int hold);
      int p0;
      logic [N-1:0] mask;
      mask = N'(1) << who;
      applyStimulus(who, a, b);
      req_valid = mask;
      #1;
      checkOutput("req_ready", req_ready, mask);
      p0 = rst_pulses;
      tick();
      req_valid = '0;
      checkOutput("grant_id", grant_id, who);
      checkOutput("mul_rst_load", mul_rst, 1);
      checkOutput("mul_ops", {mul_a, mul_b}, {a, b});
      checkOutput("busy_set", busy, 1);
      wait_response(who, exp, hold);
      checkOutput("mul_rst_pulses", rst_pulses - p0, 1);
   endtask

   initial begin
      int seen;
      rst = 1'b0;
      req_valid = '1;
      req_a = '0;
      req_b = '0;
      rsp_ready = '0;

      // Reset held with every requester asking
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("rst_req_ready", req_ready, 0);
         checkOutput("rst_rsp_valid", rsp_valid, 0);
         checkOutput("rst_busy", busy, 0);
      end
      checkOutput("rst_outputs", {grant_id, mul_rst, mul_a, mul_b, rsp_prod}, 0);
      rst = 1'b1;
      #1;
      checkOutput("first_idle_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      checkOutput("first_grant", grant_id, 0);
      wait_response(0, 32'h0, 0);

      // Single request with a stalled consumer
      run_single(0, 16'd7, 16'(-3), 32'hFFFF_FFEB, 5);

      // Fairness from a fresh reset
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < N; i++) applyStimulus(i, 16'(i + 2), 16'd1000);
      acc_id.delete();
      acc_cyc.delete();
      rsp_id.delete();
      rsp_val.delete();
      rsp_ready = '1;
      req_valid = '1;
      for (int t = 0; t < 200 && acc_id.size() < 5; t++) tick();
      req_valid = '0;
      for (int t = 0; t < 100 && rsp_id.size() < 5; t++) tick();
      rsp_ready = '0;
      tick();
      checkOutput("fair_accepts", acc_id.size(), 5);
      checkOutput("fair_responses", rsp_id.size(), 5);
      if (acc_id.size() >= 5 && rsp_id.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
            checkOutput("fair_order", acc_id[i], i % N);
            checkOutput("fair_rsp_id", rsp_id[i], i % N);
            checkOutput("fair_prod", rsp_val[i], 32'((i % N + 2) * 1000));
            if (i > 0) checkOutput("fair_period", acc_cyc[i] - acc_cyc[i-1], W + 5);
         end
      end

      // Pointer wrap: after serving req2, req3 beats req1
      run_single(2, 16'(-5), 16'd6, 32'hFFFF_FFE2, 0);
      applyStimulus(1, 16'd100, 16'(-2));
      applyStimulus(3, 16'(-9), 16'(-9));
      req_valid = 4'b1010;
      #1;
      checkOutput("wrap_ready_first", req_ready, 4'b1000);
      tick();
      req_valid = 4'b0010;
      checkOutput("wrap_grant_first", grant_id, 3);
      wait_response(3, 32'h0000_0051, 1);
      #1;
      checkOutput("wrap_ready_second", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      checkOutput("wrap_grant_second", grant_id, 1);
      wait_response(1, 32'hFFFF_FF38, 0);

      // Abort in the 8th RUN cycle
      applyStimulus(0, 16'd300, 16'd300);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      repeat (8) tick();
      checkOutput("abort_busy_run", {busy, mul_rst}, 2'b10);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checkOutput("abort_state", {busy, rsp_valid, req_ready}, 0);
      seen = 0;
      repeat (30) begin
         tick();
         if (rsp_valid != 0) seen = 1;
      end
      checkOutput("abort_no_rsp", seen, 0);
      run_single(0, 16'd32767, 16'd32767, 32'h3FFF_0001, 0);

      // Negative times negative
      run_single(2, 16'(-1234), 16'(-5678), 32'h006A_E9BC, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
